// File: rtl/instr_fetch_decode.sv
// Multi-cycle fetch/decode stage: fetches one LEGv8-subset word, decodes it, and issues it to execute.
// Optional build macro HALT_ON_ILLEGAL_EN: stop in HALT after issuing an illegal instruction.
module instr_fetch_decode #(
   parameter int                  PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   parameter int                  PC_STEP  = 4
) (
   input  logic                clock,
   input  logic                reset,
   output logic [PC_WIDTH-1:0] imem_addr,
   output logic                imem_req,
   input  logic                imem_ack,
   input  logic [31:0]         imem_data,
   output logic                issue_valid,
   input  logic                issue_ready,
   output logic [4:0]          SA,
   output logic [4:0]          SB,
   output logic [4:0]          DA,
   output logic                W,
   output logic [1:0]          alu_op,
   output logic                use_imm,
   output logic [31:0]         imm,
   output logic                mem_read,
   output logic                mem_write,
   output logic                illegal,
   output logic [PC_WIDTH-1:0] pc_out
);

   localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [9:0]  OP_SUBI = 10'b1101000100;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DECODE = 2'd1,
`ifdef HALT_ON_ILLEGAL_EN
      ISSUE  = 2'd2,
      HALT   = 2'd3
`else
      ISSUE  = 2'd2
`endif
   } state_t;

   typedef struct packed {
      logic [4:0]  sa;
      logic [4:0]  sb;
      logic [4:0]  da;
      logic        w;
      logic [1:0]  alu_op;
      logic        use_imm;
      logic [31:0] imm;
      logic        mem_read;
      logic        mem_write;
      logic        illegal;
   } dec_t;

   // Decode-field reset value; also the pattern driven for an unsupported opcode (minus illegal).
   localparam dec_t DEC_IDLE = '{sa: 5'd31, sb: 5'd31, da: 5'd31, w: 1'b0, alu_op: 2'b00,
                                 use_imm: 1'b0, imm: 32'd0, mem_read: 1'b0,
                                 mem_write: 1'b0, illegal: 1'b0};

   state_t        state, next_state;
   logic [31:0]   ir;
   logic [PC_WIDTH-1:0] pc;
   dec_t          dec, dec_q;
   logic          fetch_done;
   logic          issue_done;

   assign fetch_done = (state == FETCH) && imem_req && imem_ack;
   assign issue_done = (state == ISSUE) && issue_valid && issue_ready;

   function automatic dec_t rtype(input logic [31:0] i, input logic [1:0] op);
      dec_t d;
      d         = DEC_IDLE;
      d.sa      = i[9:5];
      d.sb      = i[20:16];
      d.da      = i[4:0];
      d.w       = 1'b1;
      d.alu_op  = op;
      return d;
   endfunction

   function automatic dec_t itype(input logic [31:0] i, input logic [1:0] op);
      dec_t d;
      d         = DEC_IDLE;
      d.sa      = i[9:5];
      d.da      = i[4:0];
      d.w       = 1'b1;
      d.alu_op  = op;
      d.use_imm = 1'b1;
      d.imm     = {20'd0, i[21:10]};
      return d;
   endfunction

   function automatic dec_t dtype(input logic [31:0] i);
      dec_t d;
      d         = DEC_IDLE;
      d.sa      = i[9:5];
      d.use_imm = 1'b1;
      d.imm     = {{23{i[20]}}, i[20:12]};
      return d;
   endfunction

   // NOTE: every field gets a default before the case, so no latch can be inferred.
   always_comb begin
      dec         = DEC_IDLE;
      dec.illegal = 1'b1;
      case (ir[31:21])
         OP_ADD:  dec = rtype(ir, 2'b00);
         OP_SUB:  dec = rtype(ir, 2'b01);
         OP_AND:  dec = rtype(ir, 2'b10);
         OP_ORR:  dec = rtype(ir, 2'b11);
         OP_LDUR: begin
            dec          = dtype(ir);
            dec.da       = ir[4:0];
            dec.w        = 1'b1;
            dec.mem_read = 1'b1;
         end
         OP_STUR: begin
            dec           = dtype(ir);
            dec.sb        = ir[4:0];
            dec.mem_write = 1'b1;
         end
         default: begin
            case (ir[31:22])
               OP_ADDI: dec = itype(ir, 2'b00);
               OP_SUBI: dec = itype(ir, 2'b01);
               default: ;
            endcase
         end
      endcase
   end

   always_comb begin
      next_state = state;
      case (state)
         FETCH:  if (fetch_done) next_state = DECODE;
         DECODE: next_state = ISSUE;
         ISSUE: begin
`ifdef HALT_ON_ILLEGAL_EN
            if (issue_done) next_state = dec_q.illegal ? HALT : FETCH;
`else
            if (issue_done) next_state = FETCH;
`endif
         end
`ifdef HALT_ON_ILLEGAL_EN
         HALT:   next_state = HALT;
`endif
         default: next_state = FETCH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (reset) state <= FETCH;
      else       state <= next_state;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         issue_valid <= 1'b0;
         ir          <= 32'd0;
         dec_q       <= DEC_IDLE;
      end else begin
         // Request rises the cycle after FETCH is entered, giving the 4-cycle instruction period.
         imem_req    <= (state == FETCH) && !fetch_done;
         issue_valid <= (next_state == ISSUE);
         if (fetch_done)                          ir    <= imem_data;
         if (state == DECODE)                     dec_q <= dec;
         if (issue_done && next_state == FETCH)   pc    <= pc + STEP;
      end
   end

   assign imem_addr = pc;
   assign pc_out    = pc;
   assign SA        = dec_q.sa;
   assign SB        = dec_q.sb;
   assign DA        = dec_q.da;
   assign W         = dec_q.w;
   assign alu_op    = dec_q.alu_op;
   assign use_imm   = dec_q.use_imm;
   assign imm       = dec_q.imm;
   assign mem_read  = dec_q.mem_read;
   assign mem_write = dec_q.mem_write;
   assign illegal   = dec_q.illegal;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed scoreboard bench for instr_fetch_decode; honours HALT_ON_ILLEGAL_EN if defined.
module tb_instr_fetch_decode;

   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_data = 32'd0;
   logic        issue_valid;
   logic        issue_ready = 1'b0;
   logic [4:0]  SA, SB, DA;
   logic        W;
   logic [1:0]  alu_op;
   logic        use_imm;
   logic [31:0] imm;
   logic        mem_read, mem_write, illegal;
   logic [31:0] pc_out;

   instr_fetch_decode #(.PC_WIDTH(32), .RESET_PC(RESET_PC), .PC_STEP(4)) dut (
      .clock(clock), .reset(reset),
      .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .SA(SA), .SB(SB), .DA(DA), .W(W), .alu_op(alu_op), .use_imm(use_imm), .imm(imm),
      .mem_read(mem_read), .mem_write(mem_write), .illegal(illegal), .pc_out(pc_out)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [4:0]  sa, sb, da;
      logic        w;
      logic [1:0]  alu_op;
      logic        use_imm;
      logic [31:0] imm;
      logic        mem_read, mem_write, illegal;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_mis = 0;
   logic [31:0] exp_pc;

   function automatic exp_t mk(input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] da,
                               input logic w, input logic [1:0] op, input logic ui,
                               input logic [31:0] im, input logic mr, input logic mw,
                               input logic il);
      exp_t e;
      e = '{sa: sa, sb: sb, da: da, w: w, alu_op: op, use_imm: ui, imm: im,
            mem_read: mr, mem_write: mw, illegal: il};
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_req"}, 32'(imem_req), 32'd1);
   endtask

   task automatic check_issue(input string tag, input exp_t e);
      check({tag, "_valid"}, 32'(issue_valid), 32'd1);
      check({tag, "_SA"}, 32'(SA), 32'(e.sa));
      check({tag, "_SB"}, 32'(SB), 32'(e.sb));
      check({tag, "_DA"}, 32'(DA), 32'(e.da));
      check({tag, "_W"}, 32'(W), 32'(e.w));
      check({tag, "_mem_read"}, 32'(mem_read), 32'(e.mem_read));
      check({tag, "_mem_write"}, 32'(mem_write), 32'(e.mem_write));
      check({tag, "_illegal"}, 32'(illegal), 32'(e.illegal));
      check({tag, "_pc_out"}, pc_out, exp_pc);
      check({tag, "_req_low"}, 32'(imem_req), 32'd0);
      if (!e.illegal) begin
         check({tag, "_alu_op"}, 32'(alu_op), 32'(e.alu_op));
         check({tag, "_use_imm"}, 32'(use_imm), 32'(e.use_imm));
      end
      if (e.use_imm) check({tag, "_imm"}, imm, e.imm);
   endtask

   // One full fetch/decode/issue transaction; hold = cycles issue_ready stays low in ISSUE.
   task automatic do_instr(input string tag, input logic [31:0] word, input exp_t e,
                           input int hold);
      exp_t got;
      logic halted;
      issue_ready = (hold == 0);
      wait_req(tag);
      check({tag, "_addr"}, imem_addr, exp_pc);
      imem_ack  = 1'b1;
      imem_data = word;
      sb_q.push_back(e);
      tick();
      imem_ack  = 1'b0;
      imem_data = 32'hDEAD_BEEF;
      check({tag, "_dec_req"}, 32'(imem_req), 32'd0);
      check({tag, "_dec_valid"}, 32'(issue_valid), 32'd0);
      tick();
      check({tag, "_q_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
      got = (sb_q.size() != 0) ? sb_q.pop_front() : e;
      check_issue(tag, got);
      for (int i = 0; i < hold; i++) begin
         imem_ack  = 1'b1;
         imem_data = 32'hCB030041;
         tick();
         imem_ack  = 1'b0;
         check_issue({tag, "_hold"}, got);
         check({tag, "_hold_addr"}, imem_addr, exp_pc);
      end
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      check({tag, "_post_valid"}, 32'(issue_valid), 32'd0);
`ifdef HALT_ON_ILLEGAL_EN
      halted = got.illegal;
`else
      halted = 1'b0;
`endif
      if (!halted) exp_pc = exp_pc + 32'd4;
      check({tag, "_next_addr"}, imem_addr, exp_pc);
      check({tag, "_gap_req"}, 32'(imem_req), 32'd0);
      if (!halted) begin
         tick();
         check({tag, "_refetch_req"}, 32'(imem_req), 32'd1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_pc = RESET_PC;
      reset  = 1'b1;
      tick();
      tick();
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(issue_valid), 32'd0);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_SA", 32'(SA), 32'd31);
      check("rst_SB", 32'(SB), 32'd31);
      check("rst_DA", 32'(DA), 32'd31);
      check("rst_W", 32'(W), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      check("rst_use_imm", 32'(use_imm), 32'd0);
      check("rst_imm", imm, 32'd0);
      check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      reset = 1'b0;
      tick();
      check("first_req", 32'(imem_req), 32'd1);

      do_instr("add0",  32'h8B020020, mk(5'd1, 5'd2, 5'd0, 1, 2'b00, 0, 32'd0, 0, 0, 0), 0);
      do_instr("add1",  32'h8B020020, mk(5'd1, 5'd2, 5'd0, 1, 2'b00, 0, 32'd0, 0, 0, 0), 0);
      do_instr("addi",  32'h910028A4, mk(5'd5, 5'd31, 5'd4, 1, 2'b00, 1, 32'h0000000A, 0, 0, 0), 0);
      do_instr("ldur",  32'hF85F8062, mk(5'd3, 5'd31, 5'd2, 1, 2'b00, 1, 32'hFFFFFFF8, 1, 0, 0), 0);
      do_instr("stur",  32'hF8010062, mk(5'd3, 5'd2, 5'd31, 0, 2'b00, 1, 32'h00000010, 0, 1, 0), 5);
      do_instr("sub",   32'hCB030041, mk(5'd2, 5'd3, 5'd1, 1, 2'b01, 0, 32'd0, 0, 0, 0), 0);
      do_instr("and",   32'h8A0700C5, mk(5'd6, 5'd7, 5'd5, 1, 2'b10, 0, 32'd0, 0, 0, 0), 0);
      do_instr("orr31", 32'hAA09011F, mk(5'd8, 5'd9, 5'd31, 1, 2'b11, 0, 32'd0, 0, 0, 0), 0);
      do_instr("subi",  32'hD13FFD6A, mk(5'd11, 5'd31, 5'd10, 1, 2'b01, 1, 32'h00000FFF, 0, 0, 0), 0);
      do_instr("illeg", 32'h00000000, mk(5'd31, 5'd31, 5'd31, 0, 2'b00, 0, 32'd0, 0, 0, 1), 0);
`ifdef HALT_ON_ILLEGAL_EN
      for (int i = 0; i < 6; i++) begin
         tick();
         check("halt_req", 32'(imem_req), 32'd0);
         check("halt_valid", 32'(issue_valid), 32'd0);
         check("halt_addr", imem_addr, exp_pc);
      end
`else
      do_instr("after_illeg", 32'h8B020020, mk(5'd1, 5'd2, 5'd0, 1, 2'b00, 0, 32'd0, 0, 0, 0), 0);
`endif

      // Reset while in DECODE: the latched word must never issue.
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      exp_pc = RESET_PC;
      tick();
      wait_req("rstdec");
      imem_ack  = 1'b1;
      imem_data = 32'h8B020020;
      sb_q.push_back(mk(5'd1, 5'd2, 5'd0, 1, 2'b00, 0, 32'd0, 0, 0, 0));
      tick();
      imem_ack = 1'b0;
      reset    = 1'b1;
      tick();
      reset = 1'b0;
      sb_q.delete();
      check("rstdec_req", 32'(imem_req), 32'd0);
      check("rstdec_valid", 32'(issue_valid), 32'd0);
      check("rstdec_addr", imem_addr, RESET_PC);
      tick();
      check("rstdec_req1", 32'(imem_req), 32'd1);
      check("rstdec_valid1", 32'(issue_valid), 32'd0);
      check("rstdec_addr1", imem_addr, RESET_PC);

      // Reset while in ISSUE with ready low.
      imem_ack  = 1'b1;
      imem_data = 32'h910028A4;
      tick();
      imem_ack = 1'b0;
      tick();
      check("rstiss_valid_pre", 32'(issue_valid), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rstiss_valid", 32'(issue_valid), 32'd0);
      check("rstiss_req", 32'(imem_req), 32'd0);
      check("rstiss_addr", imem_addr, RESET_PC);
      check("rstiss_DA", 32'(DA), 32'd31);
      tick();
      check("rstiss_req1", 32'(imem_req), 32'd1);
      check("rstiss_valid1", 32'(issue_valid), 32'd0);

      do_instr("post_rst", 32'hAA09011F, mk(5'd8, 5'd9, 5'd31, 1, 2'b11, 0, 32'd0, 0, 0, 0), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
